// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types for the sequential accumulator ALU: opcode
//               encoding, status flag bit positions, FSM state type and a
//               status packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_LOAD   = 4'h1,
      OP_ADD    = 4'h2,
      OP_SUB    = 4'h3,
      OP_ZERO   = 4'h4,
      OP_ONE    = 4'h5,
      OP_XOR    = 4'h6,
      OP_AND    = 4'h7,
      OP_OR     = 4'h8,
      OP_SHL    = 4'h9,
      OP_SHR    = 4'hA,
      OP_ADC    = 4'hB,
      OP_MUL    = 4'hC,
      OP_RSV_D  = 4'hD,
      OP_RSV_E  = 4'hE,
      OP_STATUS = 4'hF
   } opcode_e;

   // Bit positions inside the 8-bit status register; [7:5] always read zero.
   localparam int FLAG_Z   = 0;
   localparam int FLAG_N   = 1;
   localparam int FLAG_C   = 2;
   localparam int FLAG_V   = 3;
   localparam int FLAG_ILL = 4;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

   function automatic logic [7:0] pack_status(input logic z, input logic n,
                                              input logic c, input logic v,
                                              input logic ill);
      return {3'b000, ill, v, c, n, z};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Command/result bus of alu_seq. The master issues commands
//               (valid/opcode/operand); the slave answers with ready, the
//               visible accumulator/status word and a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             done;

   modport master (
      output in_valid,
      output opcode,
      output data_in,
      input  in_ready,
      input  data_out,
      input  done
   );

   modport slave (
      input  in_valid,
      input  opcode,
      input  data_in,
      output in_ready,
      output data_out,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mul
// Description : Iterative shift-add multiplier, one partial product per
//               clock. product_lo/high_nonzero present the product including
//               the current iteration, so the owner can capture the final
//               result on the edge where last is high.
//               Only instantiated when ALU_SEQ_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul #(
   parameter int WIDTH  = 8,
   parameter int CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] product_lo,
   output logic             high_nonzero
);
   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   count;

   assign acc_next     = mplier[0] ? (acc + mcand) : acc;
   assign busy         = (count != '0);
   assign last         = (count == CNT_W'(1));
   assign product_lo   = acc_next[WIDTH-1:0];
   assign high_nonzero = |acc_next[2*WIDTH-1:WIDTH];

   // Load operands on start, then add-and-shift once per cycle until count drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         count  <= CNT_W'(CYCLES);
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential accumulator ALU with 8-bit status register and a
//               selectable status view on data_out. Single-cycle ops commit
//               on the accept edge; done pulses the following cycle.
//               Optional multi-cycle MUL enabled by macro ALU_SEQ_MUL_EN;
//               without it opcode C is treated as reserved and in_ready is
//               tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   if (WIDTH < 8 || WIDTH > 32 || MUL_CYCLES != WIDTH) begin : g_bad_cfg
      $error("alu_seq: WIDTH must be 8..32 and MUL_CYCLES must equal WIDTH");
   end

   opcode_e          op;
   logic             ready;
   logic             accept;
   logic             single_accept;
   logic             mul_start;
   logic             mul_finish;
   logic [WIDTH-1:0] mul_lo;
   logic             mul_hi_nz;

   logic [WIDTH-1:0] accum;
   logic [7:0]       status;
   logic             view;
   logic             done_pulse;

   logic             carry_in;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] alu_res;
   logic [7:0]       alu_status;
   logic [7:0]       mul_status;
   logic             alu_keep;
   logic             alu_rsv;
   logic             alu_c;
   logic             alu_v;
   logic             alu_ill;
   logic [WIDTH-1:0] out_mux;

   assign op            = opcode_e'(bus.opcode);
   assign accept        = bus.in_valid && ready;
   assign single_accept = accept && !mul_start;

`ifdef ALU_SEQ_MUL_EN
   state_e state;
   logic   mul_busy;
   logic   mul_last;

   assign mul_start  = accept && (op == OP_MUL);
   assign mul_finish = (state == S_MUL) && mul_busy && mul_last;

   // Control FSM: leave IDLE on a MUL accept, return when the last iteration commits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ready <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (mul_start) begin
                  state <= S_MUL;
                  ready <= 1'b0;
               end
            end
            S_MUL: begin
               if (mul_finish) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   alu_seq_mul #(
      .WIDTH  (WIDTH),
      .CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk          (clk),
      .rst          (rst),
      .start        (mul_start),
      .a            (accum),
      .b            (bus.data_in),
      .busy         (mul_busy),
      .last         (mul_last),
      .product_lo   (mul_lo),
      .high_nonzero (mul_hi_nz)
   );
`else
   assign ready      = 1'b1;
   assign mul_start  = 1'b0;
   assign mul_finish = 1'b0;
   assign mul_lo     = '0;
   assign mul_hi_nz  = 1'b0;
`endif

   // ADC is the only op that consumes the stored carry.
   assign carry_in = (op == OP_ADC) && status[FLAG_C];
   assign add_sum  = {1'b0, accum} + {1'b0, bus.data_in} + {{WIDTH{1'b0}}, carry_in};
   assign sub_diff = {1'b0, accum} - {1'b0, bus.data_in};

   assign mul_status = pack_status(mul_lo == '0, mul_lo[MSB], mul_hi_nz, 1'b0,
                                   status[FLAG_ILL]);

   // Single-cycle result and next status for the opcode on the bus.
   always_comb begin
      alu_res    = accum;
      alu_keep   = 1'b0;
      alu_rsv    = 1'b0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      alu_ill    = status[FLAG_ILL];
      alu_status = status;
      case (op)
         OP_NOP, OP_STATUS: alu_keep = 1'b1;
         OP_LOAD: begin
            alu_res = bus.data_in;
            alu_ill = 1'b0;
         end
         OP_ADD, OP_ADC: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (accum[MSB] == bus.data_in[MSB]) && (alu_res[MSB] != accum[MSB]);
         end
         OP_SUB: begin
            alu_res = sub_diff[WIDTH-1:0];
            alu_c   = sub_diff[WIDTH];
            alu_v   = (accum[MSB] != bus.data_in[MSB]) && (alu_res[MSB] != accum[MSB]);
         end
         OP_ZERO: alu_res = '0;
         OP_ONE:  alu_res = WIDTH'(1);
         OP_XOR:  alu_res = accum ^ bus.data_in;
         OP_AND:  alu_res = accum & bus.data_in;
         OP_OR:   alu_res = accum | bus.data_in;
         OP_SHL: begin
            alu_res = {accum[MSB-1:0], 1'b0};
            alu_c   = accum[MSB];
         end
         OP_SHR: begin
            alu_res = {1'b0, accum[MSB:1]};
            alu_c   = accum[0];
         end
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: alu_keep = 1'b1;
`endif
         default: alu_rsv = 1'b1;
      endcase

      if (alu_keep) begin
         alu_status = status;
      end else if (alu_rsv) begin
         alu_status           = status;
         alu_status[FLAG_ILL] = 1'b1;
      end else begin
         alu_status = pack_status(alu_res == '0, alu_res[MSB], alu_c, alu_v, alu_ill);
      end
   end

   // Architectural state: commit single-cycle results on accept, MUL results on its last iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum      <= '0;
         status     <= '0;
         view       <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= single_accept || mul_finish;
         if (accept) begin
            view <= (op == OP_STATUS);
         end
         if (single_accept) begin
            accum  <= alu_res;
            status <= alu_status;
         end else if (mul_finish) begin
            accum  <= mul_lo;
            status <= mul_status;
         end
      end
   end

   // Output view: accumulator, or status zero-extended.
   always_comb begin
      out_mux = accum;
      if (view) begin
         out_mux      = '0;
         out_mux[7:0] = status;
      end
   end

   assign bus.data_out = out_mux;
   assign bus.in_ready = ready;
   assign bus.done     = done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq. Commands are issued through
//               the interface; a reference model computes the visible result
//               and its due cycle, and a monitor compares on every done.
//               Covers both builds of ALU_SEQ_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;
   localparam longint unsigned MOD  = 64'd1 << W;
   localparam longint          SMAX = longint'(MOD / 2) - 1;
   localparam longint          SMIN = -longint'(MOD / 2);
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] val;
      int           due;
      logic [3:0]   op;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   ready_low_seen = 1'b0;
   exp_t sbq[$];

   longint unsigned m_acc;
   logic [7:0]      m_st;
   bit              m_view;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W), .MUL_CYCLES(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic longint sgn(input longint unsigned x);
      return (x >= MOD / 2) ? longint'(x) - longint'(MOD) : longint'(x);
   endfunction

   // Reference model: architectural effect of one accepted command.
   function automatic bit model_exec(input logic [3:0] op, input longint unsigned d);
      longint unsigned r, p;
      longint s;
      bit c, v, ill, keep, rsv, cin, is_mul;
      r = m_acc; c = 0; v = 0; ill = m_st[4]; keep = 0; rsv = 0; is_mul = 0;
      cin = m_st[2];
      case (op)
         4'h0, 4'hF: keep = 1;
         4'h1: begin r = d; ill = 0; end
         4'h2, 4'hB: begin
            if (op == 4'h2) cin = 0;
            r = m_acc + d + longint'(cin);
            c = (r >= MOD);
            r = r % MOD;
            s = sgn(m_acc) + sgn(d) + longint'(cin);
            v = (s > SMAX) || (s < SMIN);
         end
         4'h3: begin
            c = (d > m_acc);
            r = (m_acc + MOD - d) % MOD;
            s = sgn(m_acc) - sgn(d);
            v = (s > SMAX) || (s < SMIN);
         end
         4'h4: r = 0;
         4'h5: r = 1;
         4'h6: r = m_acc ^ d;
         4'h7: r = m_acc & d;
         4'h8: r = m_acc | d;
         4'h9: begin c = m_acc[W-1]; r = (m_acc * 2) % MOD; end
         4'hA: begin c = m_acc[0];   r = m_acc / 2; end
         4'hC: begin
            if (MUL_EN) begin
               p = m_acc * d;
               r = p % MOD;
               c = (p / MOD) != 0;
               is_mul = 1;
            end else begin
               rsv = 1;
            end
         end
         default: rsv = 1;
      endcase
      if (rsv) m_st[4] = 1'b1;
      else if (!keep) begin
         m_acc = r;
         m_st  = {3'b000, ill, v, c, r[W-1], r == 0};
      end
      m_view = (op == 4'hF);
      return is_mul;
   endfunction

   task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one command; called just after a rising edge. Pushes the expected done.
   task automatic send(input logic [3:0] op, input logic [W-1:0] d,
                       input bit use_exp, input logic [W-1:0] exp);
      int   waited;
      bit   is_mul;
      exp_t e;
      waited = 0;
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.data_in  = d;
      @(negedge clk);
      while (!bus.in_ready && waited < 4 * W) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout op=%h: got in_ready 0 expected 1", op);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      is_mul = model_exec(op, 64'(d));
      e.val = use_exp ? exp : (m_view ? W'(m_st) : W'(m_acc));
      e.due = cyc + (is_mul ? W : 0);
      e.op  = op;
      sbq.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (!bus.in_ready) ready_low_seen = 1'b1;
         if (bus.done) begin
            tests++;
            if (sbq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done: got done 1 expected 0 (data_out %0h)", bus.data_out);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               if (bus.data_out !== e.val) begin
                  fails++;
                  $display("FAIL done_value op=%h: got %0h expected %0h", e.op, bus.data_out, e.val);
               end else if (cyc != e.due) begin
                  fails++;
                  $display("FAIL done_cycle op=%h: got cycle %0d expected %0d", e.op, cyc, e.due);
               end
            end
         end
      end
   end

   initial begin
      logic [W-1:0] d;
      logic [3:0]   op;
      int           lowcnt;

      bus.in_valid = 1'b0;
      bus.opcode   = 4'h0;
      bus.data_in  = '0;
      m_acc = 0; m_st = 8'h00; m_view = 0;

      repeat (2) @(negedge clk);
      check("reset_data_out", 64'(bus.data_out), 0);
      check("reset_done", 64'(bus.done), 0);
      check("reset_in_ready", 64'(bus.in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Carry out to zero
      send(OP_LOAD,   8'hFF, 1, 8'hFF);
      send(OP_ADD,    8'h01, 1, 8'h00);
      send(OP_STATUS, 8'h00, 1, 8'h05);
      // Signed overflow, then borrow
      send(OP_LOAD,   8'h7F, 1, 8'h7F);
      send(OP_ADD,    8'h01, 1, 8'h80);
      send(OP_STATUS, 8'h00, 1, 8'h0A);
      send(OP_SUB,    8'h81, 1, 8'hFF);
      send(OP_STATUS, 8'h00, 1, 8'h06);
      // Reserved opcode: sticky ILL, cleared by LOAD
      send(OP_RSV_D,  8'h3C, 1, 8'hFF);
      send(OP_STATUS, 8'h00, 1, 8'h16);
      send(OP_LOAD,   8'h00, 1, 8'h00);
      send(OP_STATUS, 8'h00, 1, 8'h01);
      send(OP_NOP,    8'h55, 1, 8'h00);
      // Shifts, ADC, logic, ZERO
      send(OP_ONE,    8'h00, 1, 8'h01);
      send(OP_SHL,    8'h00, 1, 8'h02);
      send(OP_LOAD,   8'h81, 1, 8'h81);
      send(OP_SHR,    8'h00, 1, 8'h40);
      send(OP_STATUS, 8'h00, 1, 8'h04);
      send(OP_LOAD,   8'hFF, 1, 8'hFF);
      send(OP_ADD,    8'h01, 1, 8'h00);
      send(OP_ADC,    8'h05, 1, 8'h06);
      send(OP_LOAD,   8'h0F, 1, 8'h0F);
      send(OP_XOR,    8'hFF, 1, 8'hF0);
      send(OP_STATUS, 8'h00, 1, 8'h02);
      send(OP_ZERO,   8'h77, 1, 8'h00);
      send(OP_STATUS, 8'h00, 1, 8'h01);

`ifdef ALU_SEQ_MUL_EN
      // Multiply: busy window, ignored in_valid pulses, product flags
      send(OP_LOAD, 8'h12, 1, 8'h12);
      send(OP_MUL,  8'h34, 1, 8'hA8);
      lowcnt = 0;
      for (int i = 0; i < 4 * W; i++) begin
         bus.in_valid = (i < W - 2);
         bus.opcode   = OP_LOAD;
         bus.data_in  = 8'h00;
         @(negedge clk);
         if (i == 1) check("mul_pre_accum_view", 64'(bus.data_out), 64'h12);
         if (bus.in_ready) break;
         lowcnt++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("mul_ready_low_cycles", 64'(lowcnt), 64'(W));
      @(posedge clk); #1;
      send(OP_STATUS, 8'h00, 1, 8'h06);

      // Reset in the middle of a multiply: no commit, no done
      send(OP_LOAD, 8'h0B, 1, 8'h0B);
      send(OP_MUL,  8'h0D, 0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      sbq.delete();
      m_acc = 0; m_st = 8'h00; m_view = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_mul_in_ready", 64'(bus.in_ready), 1);
      check("rst_mid_mul_data_out", 64'(bus.data_out), 0);
      repeat (2 * W) @(posedge clk);
      #1;
      send(OP_STATUS, 8'h00, 1, 8'h00);
`else
      // Opcode C is reserved in this build
      send(OP_LOAD,   8'h5A, 1, 8'h5A);
      send(OP_MUL,    8'h33, 1, 8'h5A);
      send(OP_STATUS, 8'h00, 1, 8'h10);
`endif

      // Randomized command stream against the model
      for (int n = 0; n < 250; n++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = OP_STATUS;
         case ($urandom_range(0, 7))
            0: d = '0;
            1: d = '1;
            2: d = W'(1) << (W - 1);
            3: d = ~(W'(1) << (W - 1));
            default: d = W'($urandom());
         endcase
         send(op, d, 0, '0);
      end

      repeat (W + 4) @(negedge clk);
      check("scoreboard_drained", 64'(sbq.size()), 0);
      if (!MUL_EN) check("in_ready_never_low", 64'(ready_low_seen), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
